// File: rtl/multi_edge_detector.sv
// N-channel synchronised, debounced edge detector with per-channel edge select,
// sticky pending flags and a combined interrupt.
module multi_edge_detector #(
  parameter int unsigned CHANNELS      = 4,
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned FILTER_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [CHANNELS-1:0]   signal,
  input  logic [2*CHANNELS-1:0] mode,
  input  logic [CHANNELS-1:0]   clr_pend,
  output logic [CHANNELS-1:0]   tick,
  output logic [CHANNELS-1:0]   rise,
  output logic [CHANNELS-1:0]   fall,
  output logic [CHANNELS-1:0]   level,
  output logic [CHANNELS-1:0]   pend,
  output logic                  irq
);

  localparam int unsigned     CntW   = $clog2(FILTER_CYCLES + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(FILTER_CYCLES - 1);
  localparam logic [CntW-1:0] CntOne = CntW'(1);

  logic [SYNC_STAGES-1:0][CHANNELS-1:0] sync_q;
  logic [CHANNELS-1:0]                  s;
  logic [CHANNELS-1:0]                  pend_next;
  logic                                 irq_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], signal};
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            level_q, level_d;
    logic            rise_q, rise_d;
    logic            fall_q, fall_d;
    logic            tick_q, tick_d;
    logic            pend_q, pend_d;

    // Any sample that agrees with the accepted level discards the partial count.
    always_comb begin
      cnt_d   = '0;
      level_d = level_q;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      if (s[i] != level_q) begin
        if (cnt_q == CntMax) begin
          level_d = s[i];
          rise_d  = s[i];
          fall_d  = ~s[i];
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      tick_d = (rise_d & mode[2*i]) | (fall_d & mode[2*i+1]);
      // A new tick beats a coincident clear.
      pend_d = tick_d | (pend_q & ~clr_pend[i]);
    end

    always_ff @(posedge clk) begin
      if (!rst) begin
        cnt_q   <= '0;
        level_q <= 1'b0;
        rise_q  <= 1'b0;
        fall_q  <= 1'b0;
        tick_q  <= 1'b0;
        pend_q  <= 1'b0;
      end else begin
        cnt_q   <= cnt_d;
        level_q <= level_d;
        rise_q  <= rise_d;
        fall_q  <= fall_d;
        tick_q  <= tick_d;
        pend_q  <= pend_d;
      end
    end

    assign pend_next[i] = pend_d;
    assign tick[i]      = tick_q;
    assign rise[i]      = rise_q;
    assign fall[i]      = fall_q;
    assign level[i]     = level_q;
    assign pend[i]      = pend_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= |pend_next;
    end
  end

  assign irq = irq_q;

endmodule

// File: tb/tb_multi_edge_detector.sv
// Directed bench for multi_edge_detector: expected output events are queued when
// stimulus is driven and compared every cycle against the DUT.
module tb_multi_edge_detector;

  localparam int unsigned CH = 4;
  localparam int unsigned SS = 2;
  localparam int unsigned FC = 4;
  // Edge at which an input change driven after edge k shows up at the outputs.
  localparam int EV = SS + FC;

  logic          clk = 1'b0;
  logic          rst;
  logic [CH-1:0] signal;
  logic [2*CH-1:0] mode;
  logic [CH-1:0] clr_pend;
  logic [CH-1:0] tick, rise, fall, level, pend;
  logic          irq;

  multi_edge_detector #(
    .CHANNELS     (CH),
    .SYNC_STAGES  (SS),
    .FILTER_CYCLES(FC)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .signal  (signal),
    .mode    (mode),
    .clr_pend(clr_pend),
    .tick    (tick),
    .rise    (rise),
    .fall    (fall),
    .level   (level),
    .pend    (pend),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            cyc;
    logic [CH-1:0] tick;
    logic [CH-1:0] rise;
    logic [CH-1:0] fall;
    logic [CH-1:0] level;
    logic [CH-1:0] pend;
    logic          irq;
  } ev_t;

  ev_t           q[$];
  ev_t           e;
  int            cyc = 0;
  int            checks = 0;
  int            errors = 0;
  bit            chk_en = 1'b0;
  logic [CH-1:0] exp_level = '0;
  logic [CH-1:0] exp_pend = '0;
  logic          exp_irq = 1'b0;
  int            k;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic push(input int c, input logic [CH-1:0] t, input logic [CH-1:0] r,
                      input logic [CH-1:0] f, input logic [CH-1:0] l,
                      input logic [CH-1:0] p, input logic i);
    q.push_back('{c, t, r, f, l, p, i});
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Event cycles compare the queued values; all other cycles must hold steady.
  always @(negedge clk) begin
    if (chk_en) begin
      if (q.size() > 0 && q[0].cyc < cyc) begin
        chk("event_schedule", q[0].cyc, cyc);
        void'(q.pop_front());
      end
      if (q.size() > 0 && q[0].cyc == cyc) begin
        e = q.pop_front();
        chk("ev_tick", tick, e.tick);
        chk("ev_rise", rise, e.rise);
        chk("ev_fall", fall, e.fall);
        chk("ev_level", level, e.level);
        chk("ev_pend", pend, e.pend);
        chk("ev_irq", irq, e.irq);
        exp_level = e.level;
        exp_pend  = e.pend;
        exp_irq   = e.irq;
      end else begin
        chk("idle_pulses", {tick, rise, fall}, '0);
        chk("idle_level", level, exp_level);
        chk("idle_pend", pend, exp_pend);
        chk("idle_irq", irq, exp_irq);
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog cyc=%0d observed=timeout expected=finish", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset held with all inputs high; rising edges follow release.
    rst      = 1'b0;
    signal   = '1;
    mode     = 8'b01_01_01_01;
    clr_pend = '0;
    step(1);
    chk_en = 1'b1;
    step(2);
    rst = 1'b1;
    k   = cyc;
    push(k + EV, 4'hF, 4'hF, 4'h0, 4'hF, 4'hF, 1'b1);
    step(EV + 2);

    k = cyc;
    clr_pend = 4'hF;
    push(k + 1, 4'h0, 4'h0, 4'h0, 4'hF, 4'h0, 1'b0);
    step(1);
    clr_pend = '0;

    // Falling edges in mode 01 move level but do not tick.
    k = cyc;
    signal = '0;
    push(k + EV, 4'h0, 4'h0, 4'hF, 4'h0, 4'h0, 1'b0);
    step(EV + 2);

    // Debounce: a 3-cycle pulse is rejected.
    signal[0] = 1'b1;
    step(3);
    signal[0] = 1'b0;
    step(10);

    // Debounce: a 4-cycle pulse is accepted, then falls back.
    k = cyc;
    signal[0] = 1'b1;
    push(k + EV, 4'h1, 4'h1, 4'h0, 4'h1, 4'h1, 1'b1);
    step(4);
    k = cyc;
    signal[0] = 1'b0;
    push(k + EV, 4'h0, 4'h0, 4'h1, 4'h0, 4'h1, 1'b1);
    step(EV + 2);
    k = cyc;
    clr_pend = 4'hF;
    push(k + 1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
    step(1);
    clr_pend = '0;

    // Modes 00/01/10/11 on ch0..ch3 with the same 0->1->0 stimulus.
    mode = 8'b11_10_01_00;
    step(1);
    k = cyc;
    signal = 4'hF;
    push(k + EV, 4'b1010, 4'hF, 4'h0, 4'hF, 4'b1010, 1'b1);
    step(8);
    k = cyc;
    signal = 4'h0;
    push(k + EV, 4'b1100, 4'h0, 4'hF, 4'h0, 4'b1110, 1'b1);
    step(EV + 2);
    k = cyc;
    clr_pend = 4'hF;
    push(k + 1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
    step(1);
    clr_pend = '0;

    // Pending flags on ch2: set, clear, then clear coincident with a tick.
    mode = 8'b00_11_00_00;
    k = cyc;
    signal = 4'b0100;
    push(k + EV, 4'b0100, 4'b0100, 4'h0, 4'b0100, 4'b0100, 1'b1);
    step(EV + 2);
    k = cyc;
    clr_pend = 4'b0100;
    push(k + 1, 4'h0, 4'h0, 4'h0, 4'b0100, 4'h0, 1'b0);
    step(1);
    clr_pend = '0;
    k = cyc;
    signal = 4'h0;
    push(k + EV, 4'b0100, 4'h0, 4'b0100, 4'h0, 4'b0100, 1'b1);
    step(EV - 1);
    clr_pend = 4'b0100;
    step(1);
    clr_pend = '0;
    step(2);
    k = cyc;
    clr_pend = 4'b0100;
    push(k + 1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
    step(1);
    clr_pend = '0;

    // Reset during a filter count forces a full stable time after release.
    mode = 8'b01_01_01_01;
    signal = 4'b0010;
    step(4);
    rst = 1'b0;
    step(1);
    rst = 1'b1;
    k = cyc;
    push(k + EV, 4'b0010, 4'b0010, 4'h0, 4'b0010, 4'b0010, 1'b1);
    step(EV + 2);
    k = cyc;
    signal   = 4'h0;
    clr_pend = 4'b0010;
    push(k + 1, 4'h0, 4'h0, 4'h0, 4'b0010, 4'h0, 1'b0);
    step(1);
    clr_pend = '0;
    push(k + EV, 4'h0, 4'h0, 4'b0010, 4'h0, 4'h0, 1'b0);
    step(EV + 1);

    // Bouncing ch1 every 2 cycles, then a steady high gives one rise.
    for (int i = 0; i < 10; i++) begin
      signal[1] = (i % 2 == 0);
      step(2);
    end
    k = cyc;
    signal[1] = 1'b1;
    push(k + EV, 4'b0010, 4'b0010, 4'h0, 4'b0010, 4'b0010, 1'b1);
    step(EV + 4);

    chk("queue_drained", q.size(), 0);
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
